row_fetch_unit: RTL and testbench

//  Upstream feeder for subpixel_interpolation. Serves row requests (row index = the

---
 rtl/row_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_row_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_fetch_unit.sv
// -----------------------------------------------------------------------------
// row_fetch_unit
// Upstream feeder for the subpixel interpolator. It accepts a row request and
// reads that row from a synchronous frame memory, one pixel per cycle. It packs
// the pixels onto in_row and presents the result with a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   base_addr    address of pixel (row 0, col 0); sampled when a request is accepted
//   req_row      requested row index
//   req_valid    request present (held by the requester until accepted)
//   req_ready    unit can accept a request (high only while idle)
//   mem_rd_en    frame-memory read strobe
//   mem_addr     frame-memory read address
//   mem_rd_data  read data, valid the cycle after mem_rd_en
//   in_row       packed row; col c at [c*PIX_W +: PIX_W], col 0 in the LSBs
//   row_valid    in_row holds a complete row
//   row_ready    consumer takes the row
//   row_err      last accepted request was out of range (sticky)
// -----------------------------------------------------------------------------
module row_fetch_unit #(
  parameter int ROW_PIX    = 15,
  parameter int NUM_ROWS   = 15,
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [7:0]               req_row,
  input  logic                     req_valid,
  output logic                     req_ready,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [PIX_W-1:0]         mem_rd_data,
  output logic [ROW_PIX*PIX_W-1:0] in_row,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic                     row_err
);

  localparam int COL_W = $clog2(ROW_PIX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] row_addr_r;   // address of column 0 of the row being fetched
  logic [COL_W-1:0]  col_r;        // number of columns issued so far
  logic [COL_W-1:0]  cap_r;        // next column slot to capture
  logic              rd_pend_r;    // a read was issued last cycle; its data is on mem_rd_data now
  logic [ADDR_W-1:0] row_addr_s;
  logic              in_range_s;

  // Row start address and range check for the request currently presented.
  // The product is truncated to ADDR_W, so the address wraps modulo 2^ADDR_W.
  always_comb begin
    row_addr_s = base_addr + (ADDR_W'(req_row) * ADDR_W'(ROW_STRIDE));
    if (int'(req_row) < NUM_ROWS) begin
      in_range_s = 1'b1;
    end else begin
      in_range_s = 1'b0;
    end
  end

  // Control FSM, read issue, data capture and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      row_addr_r <= '0;
      col_r      <= '0;
      cap_r      <= '0;
      rd_pend_r  <= 1'b0;
      req_ready  <= 1'b1;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      in_row     <= '0;
      row_valid  <= 1'b0;
      row_err    <= 1'b0;
    end else begin
      // Read data always lags its strobe by one cycle.
      rd_pend_r <= mem_rd_en;
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            row_addr_r <= row_addr_s;
            in_row     <= '0;
            if (in_range_s) begin
              // Column 0 goes out in the cycle right after the accept edge.
              row_err   <= 1'b0;
              mem_rd_en <= 1'b1;
              mem_addr  <= row_addr_s;
              col_r     <= COL_W'(1);
              cap_r     <= '0;
              state_r   <= ST_FETCH;
            end else begin
              // Bad row: present an all-zero row flagged with row_err, no reads.
              row_err   <= 1'b1;
              row_valid <= 1'b1;
              state_r   <= ST_HOLD;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_FETCH: begin
          if (col_r < COL_W'(ROW_PIX)) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= row_addr_r + ADDR_W'(col_r);
            col_r     <= col_r + COL_W'(1);
          end else begin
            mem_rd_en <= 1'b0;
          end
          if (rd_pend_r) begin
            // Constant-index decode keeps the capture mux free of wide variable shifts.
            for (int c = 0; c < ROW_PIX; c++) begin
              if (cap_r == COL_W'(c)) begin
                in_row[c*PIX_W +: PIX_W] <= mem_rd_data;
              end
            end
            if (cap_r == COL_W'(ROW_PIX - 1)) begin
              row_valid <= 1'b1;
              cap_r     <= '0;
              col_r     <= '0;
              state_r   <= ST_HOLD;
            end else begin
              cap_r <= cap_r + COL_W'(1);
            end
          end
        end

        ST_HOLD: begin
          // Row stays on the bus until the consumer takes it.
          if (row_ready) begin
            row_valid <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            row_valid <= 1'b1;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          req_ready <= 1'b1;
          mem_rd_en <= 1'b0;
          row_valid <= 1'b0;
          col_r     <= '0;
          cap_r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_row_fetch_unit
// Self-checking bench for row_fetch_unit. A random frame-memory image is held
// in an array. Expected rows are computed directly from
// base + row*ROW_STRIDE + col, and expected latencies come from the handshake
// timing rules.
// -----------------------------------------------------------------------------
module tb_row_fetch_unit;

  localparam int ROW_PIX = 15;
  localparam int NROWS   = 15;
  localparam int STRIDE  = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  base_addr;
  logic [7:0]   req_row;
  logic         req_valid;
  logic         req_ready;
  logic         mem_rd_en;
  logic [15:0]  mem_addr;
  logic [7:0]   mem_rd_data;
  logic [119:0] in_row;
  logic         row_valid;
  logic         row_ready;
  logic         row_err;

  logic [7:0]   mem [0:65535];
  int           errors = 0;
  int           checks = 0;
  int           cyc    = 0;

  row_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .base_addr   (base_addr),
    .req_row     (req_row),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .in_row      (in_row),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_err     (row_err)
  );

  always #5 clk = ~clk;

  // Synchronous frame memory: one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference row: pixel c of row r comes from base + r*STRIDE + c (mod 2^16).
  function automatic logic [119:0] model_row(input logic [15:0] b, input logic [7:0] r);
    logic [119:0] v;
    int a;
    v = '0;
    if (int'(r) < NROWS) begin
      for (int c = 0; c < ROW_PIX; c++) begin
        a = (int'(b) + int'(r) * STRIDE + c) % 65536;
        v[c*8 +: 8] = mem[a];
      end
    end
    return v;
  endfunction

  // One request, full checking of issue, latency, data, hold and release.
  task automatic run_req(input logic [15:0] b, input logic [7:0] r, input int hold, input bit pulse);
    logic [119:0] exp;
    logic [15:0]  ea;
    int           n;
    int           k;
    int           issues;
    bit           addr_ok;
    bit           stable;
    bit           rd_seen;
    exp = model_row(b, r);
    ea  = 16'((int'(b) + int'(r) * STRIDE) % 65536);
    base_addr = b;
    req_row   = r;
    row_ready = 1'b0;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", (n < 60), 1'b1);
    @(negedge clk);          // accept edge has passed
    req_valid = 1'b0;
    check("req_ready_drop", req_ready, 1'b0);
    if (int'(r) >= NROWS) begin
      check("oor_valid", row_valid, 1'b1);
      check("oor_err", row_err, 1'b1);
      check("oor_row", in_row, 120'd0);
      check("oor_rd_en", mem_rd_en, 1'b0);
    end else begin
      check("err_clear", row_err, 1'b0);
      k = 0; issues = 0; addr_ok = 1'b1;
      while (!row_valid && k < 40) begin
        if (mem_rd_en) begin
          if (mem_addr !== 16'(int'(ea) + issues)) addr_ok = 1'b0;
          issues++;
        end
        @(negedge clk);
        k++;
      end
      check("latency", k, 16);
      check("issue_cnt", issues, 15);
      check("issue_addr", addr_ok, 1'b1);
      check("row_data", in_row, exp);
    end
    stable = 1'b1; rd_seen = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 5) begin
        req_valid = 1'b1;
        req_row   = 8'd0;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (mem_rd_en) rd_seen = 1'b1;
      if (in_row !== exp || row_valid !== 1'b1 || req_ready !== 1'b0) stable = 1'b0;
    end
    req_valid = 1'b0;
    if (hold > 0) begin
      check("hold_stable", stable, 1'b1);
      check("hold_no_rd", rd_seen, 1'b0);
    end
    row_ready = 1'b1;
    @(negedge clk);
    row_ready = 1'b0;
    check("release_valid", row_valid, 1'b0);
    check("release_ready", req_ready, 1'b1);
  endtask

  initial begin
    logic [15:0] b;
    logic [7:0]  r;
    int          n;
    int          last_rise;
    bit          hit;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1; base_addr = 16'd0; req_row = 8'd0; req_valid = 1'b0; row_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_addr", mem_addr, 16'd0);
    check("rst_row", in_row, 120'd0);
    check("rst_valid", row_valid, 1'b0);
    check("rst_err", row_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);

    // Row 0 at base 0, then row 3 at base 0x0100.
    run_req(16'h0000, 8'd0, 2, 1'b0);
    run_req(16'h0100, 8'd3, 1, 1'b0);

    // Long hold with a stray request pulse.
    run_req(16'($urandom), 8'($urandom_range(0, 14)), 20, 1'b1);

    // Out-of-range row, sticky error, cleared by a good request.
    run_req(16'h0200, 8'd15, 3, 1'b0);
    check("err_sticky", row_err, 1'b1);
    run_req(16'h0200, 8'd2, 0, 1'b0);
    check("err_after_good", row_err, 1'b0);

    // Reset in the middle of a fetch.
    b = 16'($urandom);
    base_addr = b; req_row = 8'd0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0; hit = 1'b0;
    while (!hit && n < 30) begin
      if (mem_rd_en && mem_addr == 16'(b + 16'd7)) hit = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("mid_hit", hit, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rd_en", mem_rd_en, 1'b0);
    check("mid_addr", mem_addr, 16'd0);
    check("mid_row", in_row, 120'd0);
    check("mid_valid", row_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_no_late", row_valid, 1'b0);
    run_req(16'($urandom), 8'd1, 1, 1'b0);

    // Random requests, including wrap near the top of the address space.
    run_req(16'hFFF0, 8'd14, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      r = 8'($urandom_range(0, 19));
      run_req(16'($urandom), r, $urandom_range(0, 3), 1'b0);
    end

    // Back-to-back sweep of all rows with the consumer always ready.
    b = 16'($urandom);
    base_addr = b; req_row = 8'd0; row_ready = 1'b1; req_valid = 1'b1;
    last_rise = 0;
    for (int rr = 0; rr < NROWS; rr++) begin
      n = 0;
      while (!req_ready && n < 60) begin
        @(negedge clk);
        n++;
      end
      check("sweep_ready", (n < 60), 1'b1);
      @(negedge clk);
      check("sweep_accept", req_ready, 1'b0);
      if (rr < NROWS - 1) req_row = 8'(rr + 1);
      else req_valid = 1'b0;
      n = 0;
      while (!row_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("sweep_row", in_row, model_row(b, 8'(rr)));
      if (rr > 0) check("sweep_spacing", cyc - last_rise, 18);
      last_rise = cyc;
    end
    row_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
